// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// The ALU decoder uses the same operation codes.
package muldiv_pkg;

  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

  // True for the two operation codes this unit executes.
  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit.
// MUL uses one shift-add step per cycle. DIV uses one signed restoring-divide
// step per cycle. Both share one accumulator, one operand register and one
// shift register. Divide-by-zero and signed overflow go straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_ZERO = '0;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // FSM state
  muldiv_state_t state_q, state_d;

  // Datapath registers
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;       // product accumulator / partial remainder
  logic [WIDTH-1:0] opb_q, opb_d;       // shifting multiplicand / divisor magnitude
  logic [WIDTH-1:0] sh_q, sh_d;         // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Request decode
  logic             can_accept_s;
  logic             accept_s;
  logic             div_req_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic             special_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;

  // One iteration step
  logic [WIDTH-1:0] mul_sum_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   rem_diff_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0] step_opb_s;
  logic [WIDTH-1:0] step_sh_s;
  logic [WIDTH-1:0] step_result_s;

  // Decode the incoming request: accept rule, special divide cases, operand magnitudes.
  always_comb begin
    can_accept_s = (state_q == IDLE) || (state_q == DONE);
    accept_s     = start && can_accept_s && is_muldiv_op(ALUControl);
    div_req_s    = (ALUControl == ALU_DIV);
    div_zero_s   = div_req_s && (SrcB == ZERO);
    div_ovf_s    = div_req_s && (SrcA == MOST_NEG) && (SrcB == ONES);
    special_s    = div_zero_s || div_ovf_s;
    abs_a_s      = SrcA[WIDTH-1] ? (ZERO - SrcA) : SrcA;
    abs_b_s      = SrcB[WIDTH-1] ? (ZERO - SrcB) : SrcB;
  end

  // Compute one shift-add or restoring-divide step from the current registers.
  always_comb begin
    mul_sum_s   = acc_q + (sh_q[0] ? opb_q : ZERO);
    rem_shift_s = {acc_q, sh_q[WIDTH-1]};
    rem_diff_s  = rem_shift_s - {1'b0, opb_q};
    rem_ge_s    = ~rem_diff_s[WIDTH];
    if (is_div_q) begin
      step_acc_s    = rem_ge_s ? rem_diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
      step_opb_s    = opb_q;
      step_sh_s     = {sh_q[WIDTH-2:0], rem_ge_s};
      step_result_s = neg_q ? (ZERO - step_sh_s) : step_sh_s;
    end else begin
      step_acc_s    = mul_sum_s;
      step_opb_s    = {opb_q[WIDTH-2:0], 1'b0};
      step_sh_s     = {1'b0, sh_q[WIDTH-1:1]};
      step_result_s = mul_sum_s;
    end
  end

  // Next-state, datapath next values and registered status decodes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sh_d     = sh_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          is_div_d = div_req_s;
          cnt_d    = CNT_ZERO;
          acc_d    = ZERO;
          if (special_s) begin
            // No iterations needed; the answer is known at the accept edge.
            state_d  = DONE;
            neg_d    = 1'b0;
            opb_d    = ZERO;
            sh_d     = ZERO;
            result_d = div_zero_s ? ONES : MOST_NEG;
          end else if (div_req_s) begin
            state_d = RUN;
            neg_d   = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            opb_d   = abs_b_s;
            sh_d    = abs_a_s;
          end else begin
            state_d = RUN;
            neg_d   = 1'b0;
            opb_d   = SrcA;
            sh_d    = SrcB;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d = step_acc_s;
        opb_d = step_opb_s;
        sh_d  = step_sh_s;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          cnt_d    = CNT_ZERO;
          result_d = step_result_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; all of them are cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= CNT_ZERO;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= ZERO;
      opb_q    <= ZERO;
      sh_q     <= ZERO;
      result_q <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  alu_ctl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests;
  int failed;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start),
    .ALUControl (alu_ctl),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .Busy       (busy),
    .Done       (done),
    .Result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and wait, with a bound, for Done.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cyc, output int overlap,
                       output logic [31:0] res);
    start = 1'b1; alu_ctl = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D; alu_ctl = 4'b0000;
    lat = 0; busy_cyc = 0; overlap = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_cyc++;
      if (busy && done) overlap++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    res = result;
  endtask

  int          lat;
  int          bcyc;
  int          ovl;
  logic [31:0] res;

  initial begin
    tests = 0; failed = 0;
    reset_n = 1'b0; start = 1'b0; alu_ctl = 4'b0000; src_a = 32'd0; src_b = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3
    do_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, lat, bcyc, ovl, res);
    check("mul_lat", lat, 32'd33);
    check("mul_busy_cycles", bcyc, 32'd32);
    check("mul_overlap", ovl, 32'd0);
    check("mul_result", res, 32'hFFFF_FFEB);
    @(negedge clk);
    check("mul_done_low", {31'd0, done}, 32'd0);
    check("mul_busy_low", {31'd0, busy}, 32'd0);
    check("mul_result_held", result, 32'hFFFF_FFEB);

    // DIV -7 / 2 and 100 / 7
    do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcyc, ovl, res);
    check("div_neg_lat", lat, 32'd33);
    check("div_neg_result", res, 32'hFFFF_FFFD);
    @(negedge clk);
    do_op(ALU_DIV, 32'd100, 32'd7, lat, bcyc, ovl, res);
    check("div_pos_result", res, 32'd14);
    @(negedge clk);

    // Special cases: divide by zero, overflow
    do_op(ALU_DIV, 32'd5, 32'd0, lat, bcyc, ovl, res);
    check("div0_lat", lat, 32'd1);
    check("div0_busy_cycles", bcyc, 32'd0);
    check("div0_result", res, 32'hFFFF_FFFF);
    @(negedge clk);
    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, ovl, res);
    check("ovf_lat", lat, 32'd1);
    check("ovf_result", res, 32'h8000_0000);
    @(negedge clk);

    // Asynchronous reset in the middle of a MUL
    start = 1'b1; alu_ctl = ALU_MUL; src_a = 32'h0000_1234; src_b = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(ALU_MUL, 32'd3, 32'd4, lat, bcyc, ovl, res);
    check("post_rst_lat", lat, 32'd33);
    check("post_rst_result", res, 32'd12);
    @(negedge clk);

    // start pulsed during RUN with different operands is ignored
    start = 1'b1; alu_ctl = ALU_MUL; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; alu_ctl = ALU_MUL; src_a = 32'd100; src_b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 6; i <= 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("ign_run_lat", lat, 32'd33);
    check("ign_run_result", result, 32'd42);
    @(negedge clk);

    // Unsupported ALUControl in IDLE is ignored
    start = 1'b1; alu_ctl = 4'b0000; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("bad_op_busy", {31'd0, busy}, 32'd0);
    check("bad_op_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("bad_op_busy_later", {31'd0, busy}, 32'd0);
    check("bad_op_result_held", result, 32'd42);

    // Back-to-back: new start held in the DONE cycle
    do_op(ALU_MUL, 32'd9, 32'd9, lat, bcyc, ovl, res);
    check("b2b_first_result", res, 32'd81);
    do_op(ALU_MUL, 32'd2, 32'd5, lat, bcyc, ovl, res);
    check("b2b_second_lat", lat, 32'd33);
    check("b2b_second_result", res, 32'd10);
    @(negedge clk);
    check("b2b_idle_done", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
